wb_dual_port_ram: RTL and testbench



---
 rtl/wb_dual_port_ram.sv | 184 ++++++++++++++++++
 tb/tb_wb_dual_port_ram.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dual_port_ram.sv
// Dual-port Wishbone classic RAM: instruction and data ports share one word array.
// Define WBMEM_TOHOST_EN to enable the riscv-tests tohost completion monitor.
module wb_dual_port_ram #(
    parameter int    ADDR_WORDS  = 8192,
    parameter int    IWAIT       = 0,
    parameter int    DWAIT       = 0,
    parameter string INIT_FILE   = "",
    parameter int    TOHOST_WORD = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] iwb_adr_i,
    input  logic        iwb_cyc_i,
    input  logic        iwb_stb_i,
    output logic [31:0] iwb_dat_o,
    output logic        iwb_ack_o,
    input  logic [31:0] dwb_adr_i,
    input  logic [31:0] dwb_dat_i,
    output logic [31:0] dwb_dat_o,
    input  logic        dwb_we_i,
    input  logic [3:0]  dwb_sel_i,
    input  logic        dwb_cyc_i,
    input  logic        dwb_stb_i,
    output logic        dwb_ack_o,
    output logic        dwb_err_o,
    output logic        tohost_valid_o,
    output logic [31:0] tohost_data_o
);
    localparam int          AW  = $clog2(ADDR_WORDS);
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    logic [31:0] mem [ADDR_WORDS];

    // Power-up image: a sled of NOPs across the whole array
    initial begin
        for (int k = 0; k < ADDR_WORDS; k++) mem[k] = NOP;
    end

    logic unused_ok;
    assign unused_ok = ^{iwb_adr_i[1:0], dwb_adr_i[1:0]};

    state_t        i_state, i_state_nxt;
    logic [3:0]    i_cnt, i_cnt_nxt;
    logic [AW-1:0] i_idx;
    logic          i_oor, i_accept, i_resp;
    logic [31:0]   i_dat_nxt;

    state_t        d_state, d_state_nxt;
    logic [3:0]    d_cnt, d_cnt_nxt;
    logic [AW-1:0] d_idx;
    logic          d_oor, d_we, d_accept, d_resp, d_commit;
    logic          d_ack_nxt, d_err_nxt;
    logic [3:0]    d_sel;
    logic [31:0]   d_wdat, d_dat_nxt;

    assign i_accept = (i_state == ST_IDLE) && iwb_cyc_i && iwb_stb_i && !iwb_ack_o;
    assign d_accept = (d_state == ST_IDLE) && dwb_cyc_i && dwb_stb_i && !dwb_ack_o && !dwb_err_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_state   <= ST_IDLE;
            i_cnt     <= '0;
            i_idx     <= '0;
            i_oor     <= 1'b0;
            iwb_ack_o <= 1'b0;
            iwb_dat_o <= '0;
            d_state   <= ST_IDLE;
            d_cnt     <= '0;
            d_idx     <= '0;
            d_oor     <= 1'b0;
            d_we      <= 1'b0;
            d_sel     <= '0;
            d_wdat    <= '0;
            dwb_ack_o <= 1'b0;
            dwb_err_o <= 1'b0;
            dwb_dat_o <= '0;
        end else begin
            i_state   <= i_state_nxt;
            i_cnt     <= i_cnt_nxt;
            iwb_ack_o <= i_resp;
            iwb_dat_o <= i_dat_nxt;
            if (i_accept) begin
                i_idx <= iwb_adr_i[AW+1:2];
                i_oor <= (iwb_adr_i >> (AW + 2)) != 32'd0;
            end
            d_state   <= d_state_nxt;
            d_cnt     <= d_cnt_nxt;
            dwb_ack_o <= d_ack_nxt;
            dwb_err_o <= d_err_nxt;
            dwb_dat_o <= d_dat_nxt;
            if (d_accept) begin
                d_idx  <= dwb_adr_i[AW+1:2];
                d_oor  <= (dwb_adr_i >> (AW + 2)) != 32'd0;
                d_we   <= dwb_we_i;
                d_sel  <= dwb_sel_i;
                d_wdat <= dwb_dat_i;
            end
        end
    end

    // Accept loads the wait count; the response fires the cycle after it hits zero
    always_comb begin
        i_state_nxt = i_state;
        i_cnt_nxt   = i_cnt;
        i_resp      = 1'b0;
        case (i_state)
            ST_IDLE: if (i_accept) begin
                i_state_nxt = ST_WAIT;
                i_cnt_nxt   = 4'(IWAIT);
            end
            ST_WAIT: if (!iwb_cyc_i) begin
                i_state_nxt = ST_IDLE;
                i_cnt_nxt   = '0;
            end else if (i_cnt == 4'd0) begin
                i_resp      = 1'b1;
                i_state_nxt = ST_IDLE;
            end else begin
                i_cnt_nxt   = i_cnt - 4'd1;
            end
            default: i_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        d_state_nxt = d_state;
        d_cnt_nxt   = d_cnt;
        d_resp      = 1'b0;
        case (d_state)
            ST_IDLE: if (d_accept) begin
                d_state_nxt = ST_WAIT;
                d_cnt_nxt   = 4'(DWAIT);
            end
            ST_WAIT: if (!dwb_cyc_i) begin
                d_state_nxt = ST_IDLE;
                d_cnt_nxt   = '0;
            end else if (d_cnt == 4'd0) begin
                d_resp      = 1'b1;
                d_state_nxt = ST_IDLE;
            end else begin
                d_cnt_nxt   = d_cnt - 4'd1;
            end
            default: d_state_nxt = ST_IDLE;
        endcase
    end

    // Reads see the array before this edge's write lands (read-before-write)
    always_comb begin
        i_dat_nxt = iwb_dat_o;
        if (i_resp) i_dat_nxt = i_oor ? NOP : mem[i_idx];
        d_ack_nxt = d_resp && !d_oor;
        d_err_nxt = d_resp && d_oor;
        d_commit  = d_resp && !d_oor && d_we;
        d_dat_nxt = dwb_dat_o;
        if (d_resp) d_dat_nxt = d_oor ? 32'd0 : mem[d_idx];
    end

    always_ff @(posedge clk) begin
        if (d_commit) begin
            for (int b = 0; b < 4; b++)
                if (d_sel[b]) mem[d_idx][8*b +: 8] <= d_wdat[8*b +: 8];
        end
    end

`ifdef WBMEM_TOHOST_EN
    localparam logic [AW-1:0] TOHOST_IDX = TOHOST_WORD[AW-1:0];

    // Only the first nonzero tohost write is captured; the array still takes every write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tohost_valid_o <= 1'b0;
            tohost_data_o  <= '0;
        end else if (d_commit && !tohost_valid_o && d_idx == TOHOST_IDX && d_wdat != 32'd0) begin
            tohost_valid_o <= 1'b1;
            tohost_data_o  <= d_wdat;
        end
    end
`else
    assign tohost_valid_o = 1'b0;
    assign tohost_data_o  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_dual_port_ram.sv
// Directed scoreboard bench for wb_dual_port_ram (IWAIT=0, DWAIT=2, NOP-filled array).
// Exercises the tohost monitor when WBMEM_TOHOST_EN is defined, else checks the tie-offs.
module tb_wb_dual_port_ram;
    localparam int IWAIT_P = 0;
    localparam int DWAIT_P = 2;

    logic        clk;
    logic        rst_n;
    logic [31:0] iwb_adr_i;
    logic        iwb_cyc_i;
    logic        iwb_stb_i;
    logic [31:0] iwb_dat_o;
    logic        iwb_ack_o;
    logic [31:0] dwb_adr_i;
    logic [31:0] dwb_dat_i;
    logic [31:0] dwb_dat_o;
    logic        dwb_we_i;
    logic [3:0]  dwb_sel_i;
    logic        dwb_cyc_i;
    logic        dwb_stb_i;
    logic        dwb_ack_o;
    logic        dwb_err_o;
    logic        tohost_valid_o;
    logic [31:0] tohost_data_o;

    typedef struct {
        string       tag;
        logic        err;
        logic        chk;
        logic [31:0] dat;
        int          lat;
    } exp_t;

    exp_t iq[$];
    exp_t dq[$];
    int   compared   = 0;
    int   mismatched = 0;

    wb_dual_port_ram #(
        .ADDR_WORDS (8192),
        .IWAIT      (IWAIT_P),
        .DWAIT      (DWAIT_P),
        .INIT_FILE  (""),
        .TOHOST_WORD(1024)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iwb_adr_i     (iwb_adr_i),
        .iwb_cyc_i     (iwb_cyc_i),
        .iwb_stb_i     (iwb_stb_i),
        .iwb_dat_o     (iwb_dat_o),
        .iwb_ack_o     (iwb_ack_o),
        .dwb_adr_i     (dwb_adr_i),
        .dwb_dat_i     (dwb_dat_i),
        .dwb_dat_o     (dwb_dat_o),
        .dwb_we_i      (dwb_we_i),
        .dwb_sel_i     (dwb_sel_i),
        .dwb_cyc_i     (dwb_cyc_i),
        .dwb_stb_i     (dwb_stb_i),
        .dwb_ack_o     (dwb_ack_o),
        .dwb_err_o     (dwb_err_o),
        .tohost_valid_o(tohost_valid_o),
        .tohost_data_o (tohost_data_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%08h expected=%08h", tag, observed, expected);
        end
    endtask

    // Data-port transfer: push the expectation, drive, wait (bounded) for ack/err, pop and compare
    task automatic applyStimulus(input string tag, input logic [31:0] adr, input logic we,
                                 input logic [31:0] wdat, input logic [3:0] sel,
                                 input logic exp_err, input logic chk, input logic [31:0] exp_dat);
        exp_t e;
        int   n = 0;
        dq.push_back('{tag: tag, err: exp_err, chk: chk, dat: exp_dat, lat: DWAIT_P + 2});
        dwb_adr_i = adr;
        dwb_we_i  = we;
        dwb_dat_i = wdat;
        dwb_sel_i = sel;
        dwb_cyc_i = 1'b1;
        dwb_stb_i = 1'b1;
        do begin
            tick();
            n++;
        end while (!(dwb_ack_o || dwb_err_o) && n < 20);
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        dwb_we_i  = 1'b0;
        e = dq.pop_front();
        checkOutput({e.tag, "_lat"}, 32'(n), 32'(e.lat));
        checkOutput({e.tag, "_err"}, 32'(dwb_err_o), 32'(e.err));
        checkOutput({e.tag, "_ack"}, 32'(dwb_ack_o), 32'(!e.err));
        if (e.chk) checkOutput({e.tag, "_dat"}, dwb_dat_o, e.dat);
        tick();
        checkOutput({e.tag, "_off"}, 32'(dwb_ack_o | dwb_err_o), 32'd0);
    endtask

    task automatic fetchStimulus(input string tag, input logic [31:0] adr, input logic [31:0] exp_dat);
        exp_t e;
        int   n = 0;
        iq.push_back('{tag: tag, err: 1'b0, chk: 1'b1, dat: exp_dat, lat: IWAIT_P + 2});
        iwb_adr_i = adr;
        iwb_cyc_i = 1'b1;
        iwb_stb_i = 1'b1;
        do begin
            tick();
            n++;
        end while (!iwb_ack_o && n < 20);
        iwb_cyc_i = 1'b0;
        iwb_stb_i = 1'b0;
        e = iq.pop_front();
        checkOutput({e.tag, "_lat"}, 32'(n), 32'(e.lat));
        checkOutput({e.tag, "_ack"}, 32'(iwb_ack_o), 32'd1);
        checkOutput({e.tag, "_dat"}, iwb_dat_o, e.dat);
        tick();
        checkOutput({e.tag, "_off"}, 32'(iwb_ack_o), 32'd0);
    endtask

    initial begin
        exp_t ei, ed;
        logic seen;

        rst_n     = 1'b0;
        iwb_adr_i = '0;
        iwb_cyc_i = 1'b0;
        iwb_stb_i = 1'b0;
        dwb_adr_i = '0;
        dwb_dat_i = '0;
        dwb_we_i  = 1'b0;
        dwb_sel_i = '0;
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_iack", 32'(iwb_ack_o), 32'd0);
        checkOutput("rst_idat", iwb_dat_o, 32'd0);
        checkOutput("rst_dack", 32'(dwb_ack_o), 32'd0);
        checkOutput("rst_derr", 32'(dwb_err_o), 32'd0);
        checkOutput("rst_ddat", dwb_dat_o, 32'd0);
        checkOutput("rst_thv", 32'(tohost_valid_o), 32'd0);
        checkOutput("rst_thd", tohost_data_o, 32'd0);
        rst_n = 1'b1;
        tick();

        // Word 0 gets the first instruction, then the fetch port reads it back
        applyStimulus("w_word0", 32'h0, 1'b1, 32'h0000_0297, 4'hF, 1'b0, 1'b0, 32'h0);
        fetchStimulus("f_word0", 32'h0, 32'h0000_0297);

        // Byte-masked write over a known word; low address bits are ignored
        applyStimulus("r_init100", 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0013);
        applyStimulus("w_full100", 32'h100, 1'b1, 32'h1122_3344, 4'hF, 1'b0, 1'b0, 32'h0);
        applyStimulus("w_mask100", 32'h100, 1'b1, 32'hDEAD_BEEF, 4'b0101, 1'b0, 1'b0, 32'h0);
        applyStimulus("r_mask100", 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11AD_33EF);
        applyStimulus("w_sel0", 32'h100, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 32'h0);
        applyStimulus("r_sel0", 32'h103, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11AD_33EF);

        // Out-of-range data accesses error out; the write would alias word 0x40 if it leaked
        applyStimulus("r_oor", 32'h0001_0000, 1'b0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h0);
        applyStimulus("w_oor", 32'h0001_0100, 1'b1, 32'h5555_AAAA, 4'hF, 1'b1, 1'b1, 32'h0);
        applyStimulus("r_oor_chk", 32'h100, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h11AD_33EF);
        fetchStimulus("f_oor", 32'h0001_0000, 32'h0000_0013);

        // Fetch and data write of word 0x200 respond on the same edge
        dq.push_back('{tag: "same_d", err: 1'b0, chk: 1'b0, dat: 32'h0, lat: DWAIT_P + 2});
        iq.push_back('{tag: "same_i", err: 1'b0, chk: 1'b1, dat: 32'h0000_0013, lat: IWAIT_P + 2});
        dwb_adr_i = 32'h200;
        dwb_dat_i = 32'hCAFE_F00D;
        dwb_sel_i = 4'hF;
        dwb_we_i  = 1'b1;
        dwb_cyc_i = 1'b1;
        dwb_stb_i = 1'b1;
        tick();
        tick();
        iwb_adr_i = 32'h200;
        iwb_cyc_i = 1'b1;
        iwb_stb_i = 1'b1;
        tick();
        tick();
        ed = dq.pop_front();
        ei = iq.pop_front();
        checkOutput({ed.tag, "_ack"}, 32'(dwb_ack_o), 32'd1);
        checkOutput({ei.tag, "_ack"}, 32'(iwb_ack_o), 32'd1);
        checkOutput({ei.tag, "_dat"}, iwb_dat_o, ei.dat);
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        dwb_we_i  = 1'b0;
        iwb_cyc_i = 1'b0;
        iwb_stb_i = 1'b0;
        tick();
        fetchStimulus("f_after_same", 32'h200, 32'hCAFE_F00D);

        // Master gives up after one wait cycle: no ack, no write
        dwb_adr_i = 32'h300;
        dwb_dat_i = 32'hAAAA_5555;
        dwb_sel_i = 4'hF;
        dwb_we_i  = 1'b1;
        dwb_cyc_i = 1'b1;
        dwb_stb_i = 1'b1;
        tick();
        tick();
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        dwb_we_i  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            seen = seen | dwb_ack_o | dwb_err_o;
            tick();
        end
        checkOutput("abandon_noresp", 32'(seen), 32'd0);
        applyStimulus("r_abandon", 32'h300, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0013);

`ifdef WBMEM_TOHOST_EN
        applyStimulus("th_w0", 32'h1000, 1'b1, 32'h0, 4'hF, 1'b0, 1'b0, 32'h0);
        checkOutput("th_v_after0", 32'(tohost_valid_o), 32'd0);
        applyStimulus("th_w7", 32'h1000, 1'b1, 32'h7, 4'hF, 1'b0, 1'b0, 32'h0);
        checkOutput("th_v_after7", 32'(tohost_valid_o), 32'd1);
        checkOutput("th_d_after7", tohost_data_o, 32'd7);
        checkOutput("th_failcode", tohost_data_o >> 1, 32'd3);
        applyStimulus("th_w1", 32'h1000, 1'b1, 32'h1, 4'hF, 1'b0, 1'b0, 32'h0);
        checkOutput("th_v_after1", 32'(tohost_valid_o), 32'd1);
        checkOutput("th_d_after1", tohost_data_o, 32'd7);
        applyStimulus("th_mem", 32'h1000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h1);
`else
        applyStimulus("th_w7", 32'h1000, 1'b1, 32'h7, 4'hF, 1'b0, 1'b0, 32'h0);
        checkOutput("th_v_tied", 32'(tohost_valid_o), 32'd0);
        checkOutput("th_d_tied", tohost_data_o, 32'd0);
        applyStimulus("th_mem", 32'h1000, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h7);
`endif

        // Reset in the middle of a waited write drops it and clears the outputs
        dwb_adr_i = 32'h304;
        dwb_dat_i = 32'h1234_5678;
        dwb_sel_i = 4'hF;
        dwb_we_i  = 1'b1;
        dwb_cyc_i = 1'b1;
        dwb_stb_i = 1'b1;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_dack", 32'(dwb_ack_o), 32'd0);
        checkOutput("midrst_derr", 32'(dwb_err_o), 32'd0);
        checkOutput("midrst_ddat", dwb_dat_o, 32'd0);
        checkOutput("midrst_iack", 32'(iwb_ack_o), 32'd0);
        checkOutput("midrst_idat", iwb_dat_o, 32'd0);
        checkOutput("midrst_thv", 32'(tohost_valid_o), 32'd0);
        checkOutput("midrst_thd", tohost_data_o, 32'd0);
        dwb_cyc_i = 1'b0;
        dwb_stb_i = 1'b0;
        dwb_we_i  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus("r_midrst", 32'h304, 1'b0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0013);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
